// File: rtl/texture_tile_store.sv
// Parametrised texture tile store: CPU packed-word writes unpacked one texel per cycle,
// full-store hardware clear, and a 2-stage (tile, u, v) fetch pipeline with X/Y flip.
module texture_tile_store #(
  parameter int unsigned BPP        = 3,
  parameter int unsigned TILE_LOG2  = 3,
  parameter int unsigned TILES_LOG2 = 6,
  parameter int unsigned WORD_W     = 32,
  localparam int unsigned AW        = TILES_LOG2 + 2 * TILE_LOG2,
  localparam int unsigned DEPTH     = 2 ** AW,
  localparam int unsigned TPW       = WORD_W / BPP,
  localparam int unsigned CW        = $clog2(TPW + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic [CW-1:0]         wr_count,
  input  logic                  clr_start,
  input  logic [BPP-1:0]        clr_value,
  output logic                  busy,
  input  logic                  rd_valid,
  input  logic [TILES_LOG2-1:0] rd_tile,
  input  logic [TILE_LOG2-1:0]  rd_u,
  input  logic [TILE_LOG2-1:0]  rd_v,
  input  logic                  rd_flip_x,
  input  logic                  rd_flip_y,
  output logic                  rd_out_valid,
  output logic [BPP-1:0]        rd_texel
);

  typedef enum logic [1:0] {StIdle, StUnpack, StClear} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BPP-1:0]      clr_val_q, clr_val_d;
  logic [CW-1:0]       wr_count_clamped;

  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [BPP-1:0]      mem_wdata;
  logic [BPP-1:0]      mem [DEPTH];

  logic                rd_v1_q, rd_v1_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                rd_out_valid_q, rd_out_valid_d;
  logic [BPP-1:0]      rd_texel_q, rd_texel_d;
  logic [TILE_LOG2-1:0] u_eff, v_eff;

  assign wr_count_clamped = (wr_count > CW'(TPW)) ? CW'(TPW) : wr_count;
  assign busy             = (state_q != StIdle);
  assign wr_ready         = (state_q == StIdle) && !clr_start;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    clr_val_d = clr_val_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = data_q[BPP-1:0];
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d   = StClear;
          addr_d    = '0;
          clr_val_d = clr_value;
        end else if (wr_valid && wr_count_clamped != '0) begin
          // A zero-count word is accepted but never leaves idle
          state_d = StUnpack;
          addr_d  = wr_addr;
          data_d  = wr_data;
          cnt_d   = wr_count_clamped;
        end
      end
      StUnpack: begin
        mem_we = 1'b1;
        addr_d = addr_q + 1'b1;
        data_d = data_q >> BPP;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = StIdle;
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_wdata = clr_val_q;
        addr_d    = addr_q + 1'b1;
        if (addr_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      clr_val_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      clr_val_q <= clr_val_d;
    end
  end

  // Storage is deliberately not reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    u_eff          = rd_flip_x ? ~rd_u : rd_u;
    v_eff          = rd_flip_y ? ~rd_v : rd_v;
    rd_v1_d        = rd_valid;
    rd_addr_d      = {rd_tile, v_eff, u_eff};
    rd_out_valid_d = rd_v1_q;
    rd_texel_d     = rd_texel_q;
    // Read samples pre-write contents, so a same-cycle write returns old data
    if (rd_v1_q) rd_texel_d = mem[rd_addr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_out_valid_q <= 1'b0;
      rd_texel_q     <= '0;
    end else begin
      rd_v1_q        <= rd_v1_d;
      rd_addr_q      <= rd_addr_d;
      rd_out_valid_q <= rd_out_valid_d;
      rd_texel_q     <= rd_texel_d;
    end
  end

  assign rd_out_valid = rd_out_valid_q;
  assign rd_texel     = rd_texel_q;

endmodule

// File: tb/tb_texture_tile_store.sv
// Directed/randomised bench for texture_tile_store against a flat-array texel model.
module tb_texture_tile_store;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_count;
  logic        clr_start;
  logic [2:0]  clr_value;
  logic        busy;
  logic        rd_valid;
  logic [5:0]  rd_tile;
  logic [2:0]  rd_u;
  logic [2:0]  rd_v;
  logic        rd_flip_x;
  logic        rd_flip_y;
  logic        rd_out_valid;
  logic [2:0]  rd_texel;

  texture_tile_store dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_count     (wr_count),
    .clr_start    (clr_start),
    .clr_value    (clr_value),
    .busy         (busy),
    .rd_valid     (rd_valid),
    .rd_tile      (rd_tile),
    .rd_u         (rd_u),
    .rd_v         (rd_v),
    .rd_flip_x    (rd_flip_x),
    .rd_flip_y    (rd_flip_y),
    .rd_out_valid (rd_out_valid),
    .rd_texel     (rd_texel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int model [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Texel address from the fetch rules: flip mirrors within the 8-texel edge
  function automatic int fetch_addr(int tile, int u, int v, bit fx, bit fy);
    int uu = fx ? 7 - u : u;
    int vv = fy ? 7 - v : v;
    return tile * 64 + vv * 8 + uu;
  endfunction

  function automatic void model_word(int addr, int data, int count);
    int n = (count > 10) ? 10 : count;
    for (int k = 0; k < n; k++) model[(addr + k) % DEPTH] = (data >> (3 * k)) & 7;
  endfunction

  task automatic drive_rd(input int tile, input int u, input int v, input bit fx, input bit fy);
    rd_tile   = 6'(tile);
    rd_u      = 3'(u);
    rd_v      = 3'(v);
    rd_flip_x = fx;
    rd_flip_y = fy;
  endtask

  task automatic fetch_exp(input string tag, input int tile, input int u, input int v,
                           input bit fx, input bit fy, input int exp);
    drive_rd(tile, u, v, fx, fy);
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(rd_out_valid), 32'd1);
    check(tag, 32'(rd_texel), 32'(exp));
  endtask

  task automatic fetch_flat(input string tag, input int a, input int exp);
    fetch_exp(tag, a / 64, a % 8, (a / 8) % 8, 1'b0, 1'b0, exp);
  endtask

  task automatic write_word(input int addr, input int data, input int count, output int cycles);
    wr_addr  = 12'(addr);
    wr_data  = 32'(data);
    wr_count = 4'(count);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 5000) begin
      cycles++;
      tick();
    end
  endtask

  initial begin : main
    int cyc;
    int d;
    int a;
    int oldv;
    int newv;
    bit rv [25];
    int rexp [25];
    int last_exp;
    bit have_last;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_count = '0;
    clr_start = 1'b0; clr_value = '0;
    rd_valid = 1'b0;
    drive_rd(0, 0, 0, 1'b0, 1'b0);
    #3;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(rd_out_valid), 32'd0);
    check("rst_texel", 32'(rd_texel), 32'd0);
    #19 reset = 1'b0;
    tick();

    // Clear takes priority over a simultaneous write
    clr_start = 1'b1; clr_value = 3'd3;
    wr_valid = 1'b1; wr_addr = 12'd50; wr_data = 32'h0000_0249; wr_count = 4'd5;
    #1;
    check("clr_prio_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    clr_start = 1'b0; wr_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      tick();
    end
    check("clr_busy_cycles", 32'(cyc), 32'd4096);
    check("clr_wr_ready_after", 32'(wr_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) model[i] = 3;
    fetch_flat("clr_addr50", 50, 3);
    fetch_flat("clr_addr0", 0, 3);
    fetch_flat("clr_addr4095", 4095, 3);
    for (int i = 0; i < 8; i++) fetch_flat("clr_rand", $urandom_range(0, DEPTH - 1), 3);

    // Unpack 10 texels, texel k = k & 7
    d = 0;
    for (int k = 0; k < 10; k++) d = d | ((k & 7) << (3 * k));
    write_word(0, d, 10, cyc);
    check("unpack_busy_cycles", 32'(cyc), 32'd10);
    model_word(0, d, 10);
    for (int u = 0; u < 8; u++) fetch_exp("unpack_v0", 0, u, 0, 1'b0, 1'b0, u);
    fetch_exp("unpack_v1u0", 0, 0, 1, 1'b0, 1'b0, 0);
    fetch_exp("unpack_v1u1", 0, 1, 1, 1'b0, 1'b0, 1);

    // Address wrap
    d = 5 | (6 << 3) | (7 << 6) | (1 << 9);
    write_word(4094, d, 4, cyc);
    check("wrap_busy_cycles", 32'(cyc), 32'd4);
    model_word(4094, d, 4);
    fetch_flat("wrap_4094", 4094, 5);
    fetch_flat("wrap_4095", 4095, 6);
    fetch_flat("wrap_0", 0, 7);
    fetch_flat("wrap_1", 1, 1);
    fetch_flat("wrap_2_unchanged", 2, 2);

    // Random words, including zero and over-range counts
    for (int i = 0; i < 8; i++) begin
      int cnt;
      int adr;
      int dat;
      cnt = (i == 0) ? 0 : (i == 1) ? 15 : $urandom_range(0, 15);
      adr = $urandom_range(0, DEPTH - 1);
      dat = $urandom;
      write_word(adr, dat, cnt, cyc);
      check("rand_busy_cycles", 32'(cyc), 32'((cnt > 10) ? 10 : cnt));
      model_word(adr, dat, cnt);
      for (int k = 0; k < 3; k++) begin
        a = (adr + $urandom_range(0, 11)) % DEPTH;
        fetch_flat("rand_read", a, model[a]);
      end
    end

    // Tile 5: texel = u; tile 6: texel = v
    for (int v = 0; v < 8; v++) begin
      d = 0;
      for (int u = 0; u < 8; u++) d = d | (u << (3 * u));
      write_word(5 * 64 + v * 8, d, 8, cyc);
      model_word(5 * 64 + v * 8, d, 8);
      d = 0;
      for (int u = 0; u < 8; u++) d = d | (v << (3 * u));
      write_word(6 * 64 + v * 8, d, 8, cyc);
      model_word(6 * 64 + v * 8, d, 8);
    end
    fetch_exp("flip_x_u1", 5, 1, 0, 1'b1, 1'b0, 6);
    fetch_exp("noflip_u1", 5, 1, 0, 1'b0, 1'b0, 1);
    fetch_exp("flip_y_v2", 6, 3, 2, 1'b0, 1'b1, 5);
    fetch_exp("flip_xy", 6, 2, 6, 1'b1, 1'b1, 1);

    // Back-to-back fetches with random gaps
    for (int i = 0; i < 25; i++) begin
      rv[i] = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      rexp[i] = 0;
    end
    have_last = 1'b0;
    last_exp = 0;
    for (int i = 0; i < 25; i++) begin
      if (i < 24) begin
        int t = $urandom_range(0, 63);
        int u = $urandom_range(0, 7);
        int v = $urandom_range(0, 7);
        bit fx = 1'($urandom_range(0, 1));
        bit fy = 1'($urandom_range(0, 1));
        drive_rd(t, u, v, fx, fy);
        rd_valid = rv[i];
        rexp[i] = model[fetch_addr(t, u, v, fx, fy)];
      end else begin
        rd_valid = 1'b0;
        rv[i] = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check("pipe_valid", 32'(rd_out_valid), 32'(rv[i - 1]));
        if (rv[i - 1]) begin
          last_exp = rexp[i - 1];
          have_last = 1'b1;
          check("pipe_texel", 32'(rd_texel), 32'(last_exp));
        end else if (have_last) begin
          check("pipe_hold", 32'(rd_texel), 32'(last_exp));
        end
      end
    end

    // Read-during-write at address 9
    oldv = model[9];
    newv = (oldv + 1) & 7;
    wr_addr = 12'd9; wr_data = 32'(newv); wr_count = 4'd1; wr_valid = 1'b1;
    drive_rd(0, 1, 1, 1'b0, 1'b0);
    rd_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    check("rdw_valid", 32'(rd_out_valid), 32'd1);
    check("rdw_old", 32'(rd_texel), 32'(oldv));
    rd_valid = 1'b0;
    tick();
    check("rdw_new", 32'(rd_texel), 32'(newv));
    model[9] = newv;

    // Asynchronous reset 100 cycles into a clear
    clr_value = 3'd5;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    drive_rd(10, 2, 3, 1'b0, 1'b0);
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd1);
    check("abort_out_valid", 32'(rd_out_valid), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("abort_inflight_dropped", 32'(rd_out_valid), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 100; i++) model[i] = 5;
    fetch_flat("abort_lo0", 0, 5);
    fetch_flat("abort_lo50", 50, 5);
    fetch_flat("abort_lo99", 99, 5);
    fetch_flat("abort_hi100", 100, model[100]);
    fetch_flat("abort_hi101", 101, model[101]);
    fetch_flat("abort_hi320", 320, model[320]);
    fetch_flat("abort_hi4095", 4095, model[4095]);
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(110, DEPTH - 1);
      fetch_flat("abort_hi_rand", a, model[a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
